// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 16-word block, then streams (W_t, K_t)
// for rounds 0..63 with the K-ROM address run one step ahead of the pair.
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    output logic        in_ready,
    output logic [5:0]  k_addr,
    input  logic [31:0] k_in,
    output logic        round_valid,
    input  logic        round_ready,
    output logic [5:0]  round_idx,
    output logic [31:0] w_out,
    output logic [31:0] k_out,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_RUN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_win [16];
    logic [3:0]  r_cnt;
    logic [5:0]  r_t;
    logic        r_done;

    logic        w_load_acc;
    logic        w_round_acc;
    logic [31:0] w_new;
    logic [5:0]  w_k_addr;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign w_load_acc  = (r_state == S_LOAD) && in_valid;
    assign w_round_acc = (r_state == S_RUN) && round_ready;
    assign w_new       = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (w_load_acc && (r_cnt == 4'd15)) w_next = S_PRIME;
            S_PRIME: w_next = S_RUN;
            S_RUN:   if (w_round_acc && (r_t == 6'd63)) w_next = S_IDLE;
        endcase
    end

    // Address leads by one so the registered ROM output lines up with w[0]
    always_comb begin
        w_k_addr = 6'd0;
        if (r_state == S_RUN) begin
            w_k_addr = w_round_acc ? (r_t + 6'd1) : r_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_t     <= 6'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_round_acc && (r_t == 6'd63);
            if (w_load_acc) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_round_acc) begin
                r_t <= r_t + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_win[i] <= 32'd0;
            end
        end else if (w_load_acc) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= in_word;
        end else if (w_round_acc) begin
            for (int i = 0; i < 15; i++) begin
                r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_new;
        end
    end

    assign in_ready    = (r_state == S_LOAD);
    assign round_valid = (r_state == S_RUN);
    assign round_idx   = r_t;
    assign w_out       = r_win[0];
    assign k_out       = k_in;
    assign k_addr      = w_k_addr;
    assign done        = r_done;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule with a registered K-ROM model
// and a reference array-based message-schedule model.
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_word = 32'd0;
    logic        in_ready;
    logic [5:0]  k_addr;
    logic [31:0] k_in;
    logic        round_valid;
    logic        round_ready = 1'b1;
    logic [5:0]  round_idx;
    logic [31:0] w_out;
    logic [31:0] k_out;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] blk   [16];
    logic [31:0] expw  [64];
    logic [31:0] cap_w [64];
    logic [31:0] cap_k [64];

    logic [31:0] ktab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_word     (in_word),
        .in_ready    (in_ready),
        .k_addr      (k_addr),
        .k_in        (k_in),
        .round_valid (round_valid),
        .round_ready (round_ready),
        .round_idx   (round_idx),
        .w_out       (w_out),
        .k_out       (k_out),
        .done        (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        k_in <= ktab[k_addr];
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_model();
        for (int t = 0; t < 64; t++) begin
            if (t < 16) expw[t] = blk[t];
            else expw[t] = ss1(expw[t-2]) + expw[t-7] + ss0(expw[t-15]) + expw[t-16];
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_rise", 32'(in_ready), 32'd1);
    endtask

    task automatic load_block(input bit gaps, input bit extra);
        int g;
        for (int i = 0; i < 16; i++) begin
            g = (gaps && (i % 2 == 1)) ? 1 + $urandom_range(0, 1) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_word  = 32'hdeadbeef;
                start    = extra;
                @(negedge clk);
                check("in_ready_gap", 32'(in_ready), 32'd1);
            end
            start    = 1'b0;
            in_valid = 1'b1;
            in_word  = blk[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("prime_in_ready", 32'(in_ready), 32'd0);
        check("prime_valid", 32'(round_valid), 32'd0);
        check("prime_kaddr", 32'(k_addr), 32'd0);
    endtask

    task automatic run_block(input bit rand_ready, input bit extra,
                             input bit chk_lat);
        int hs;
        int cyc;
        hs  = 0;
        cyc = 1;
        while (hs < 64 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            round_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            start = extra ? ($urandom_range(0, 1) == 1) : 1'b0;
            check("run_valid", 32'(round_valid), 32'd1);
            check("run_idx", 32'(round_idx), 32'(hs));
            check("run_w", w_out, expw[hs]);
            check("run_k", k_out, ktab[hs]);
            if (hs == 0) check("run_no_done", 32'(done), 32'd0);
            cap_w[hs] = w_out;
            cap_k[hs] = k_out;
            if (round_ready) hs++;
        end
        check("handshakes", 32'(hs), 32'd64);
        @(negedge clk);
        cyc++;
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_valid_low", 32'(round_valid), 32'd0);
        check("done_idx_wrap", 32'(round_idx), 32'd0);
        if (chk_lat) check("latency", 32'(cyc), 32'd66);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(round_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx", 32'(round_idx), 32'd0);
        check("rst_w", w_out, 32'd0);
        check("rst_kaddr", 32'(k_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // FIPS "abc" block, no back-pressure
        set_abc();
        pulse_start();
        load_block(1'b0, 1'b0);
        run_block(1'b0, 1'b0, 1'b1);
        check("abc_w0", cap_w[0], 32'h61626380);
        check("abc_k0", cap_k[0], 32'h428a2f98);
        check("abc_w16", cap_w[16], 32'h61626380);
        check("abc_w17", cap_w[17], 32'h000f0000);
        check("abc_k63", cap_k[63], 32'hc67178f2);
        @(negedge clk);
        check("done_once_a", 32'(done), 32'd0);

        // random block with random back-pressure
        set_rand();
        pulse_start();
        load_block(1'b0, 1'b0);
        run_block(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("done_once_b", 32'(done), 32'd0);

        // gapped load and stray starts, then a back-to-back block
        set_abc();
        pulse_start();
        load_block(1'b1, 1'b1);
        run_block(1'b0, 1'b1, 1'b1);
        check("gap_w17", cap_w[17], 32'h000f0000);
        set_rand();
        pulse_start();
        check("b2b_done_low", 32'(done), 32'd0);
        load_block(1'b0, 1'b0);
        run_block(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("done_once_c", 32'(done), 32'd0);

        // reset in the middle of a run
        set_rand();
        pulse_start();
        load_block(1'b0, 1'b0);
        round_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_idx_pre", 32'(round_idx), 32'd19);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(round_valid), 32'd0);
        check("mid_rst_idx", 32'(round_idx), 32'd0);
        check("mid_rst_w", w_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mid_no_done", 32'(done), 32'd0);
        end
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_valid", 32'(round_valid), 32'd0);
        check("mid_idx", 32'(round_idx), 32'd0);
        check("mid_w", w_out, 32'd0);
        check("mid_kaddr", 32'(k_addr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
